// File: rtl/obi_subordinate_mem.sv
// Word-addressed OBI memory subordinate with programmable grant latency and an R-channel response FIFO.
// Optional error counter on err_cnt_o when OBI_SBR_ERR_CNT_EN is defined.
module obi_subordinate_mem #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    GNT_WAIT   = 0,
    parameter int                    RSP_DEPTH  = 2
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    obi_req_i,
    output logic                    obi_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
    input  logic                    obi_we_i,
    input  logic [DATA_WIDTH/8-1:0] obi_be_i,
    input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
    output logic                    obi_rvalid_o,
    input  logic                    obi_rready_i,
    output logic [DATA_WIDTH-1:0]   obi_rdata_o,
    output logic                    obi_err_o,
    output logic                    busy_o,
    output logic [7:0]              err_cnt_o
);
    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFFS = $clog2(NB);
    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW   = $clog2(RSP_DEPTH + 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
    } rsp_t;

    logic [3:0]            wcnt;
    logic [CW-1:0]         cnt;
    logic [PW-1:0]         wptr, rptr;
    logic                  full, empty, accept, pop, err_txn;
    logic [ADDR_WIDTH-1:0] off, idx_full;
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    rsp_t                  rsp_buf [RSP_DEPTH];
    rsp_t                  push_rsp;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full   = (cnt == CW'(RSP_DEPTH));
    assign empty  = (cnt == '0);
    // Grant is held low while reset is asserted so the A channel is quiet immediately.
    assign obi_gnt_o = reset_ni && obi_req_i && (wcnt == 4'(GNT_WAIT)) && !full;
    assign accept = obi_req_i && obi_gnt_o;
    assign pop    = !empty && obi_rready_i;

    assign off      = obi_addr_i - BASE_ADDR;
    assign idx_full = off >> OFFS;
    assign idx      = idx_full[IW-1:0];
    assign err_txn  = (obi_addr_i < BASE_ADDR) || (idx_full >= ADDR_WIDTH'(DEPTH)) ||
                      (off[OFFS-1:0] != '0);

    always_comb begin
        push_rsp.err   = err_txn;
        push_rsp.rdata = (err_txn || obi_we_i) ? '0 : mem[idx];
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wcnt <= '0;
        end else if (!obi_req_i || accept) begin
            wcnt <= '0;
        end else if (wcnt != 4'(GNT_WAIT)) begin
            wcnt <= wcnt + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (accept && obi_we_i && !err_txn) begin
            for (int k = 0; k < NB; k++)
                if (obi_be_i[k]) mem[idx][8*k +: 8] <= obi_wdata_i[8*k +: 8];
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < RSP_DEPTH; i++) rsp_buf[i] <= '0;
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (accept) begin
                rsp_buf[wptr] <= push_rsp;
                wptr          <= nxt(wptr);
            end
            if (pop) rptr <= nxt(rptr);
            case ({accept, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign obi_rvalid_o = !empty;
    assign busy_o       = !empty;
    assign obi_rdata_o  = empty ? '0 : rsp_buf[rptr].rdata;
    assign obi_err_o    = !empty && rsp_buf[rptr].err;

`ifdef OBI_SBR_ERR_CNT_EN
    logic [7:0] err_cnt_q;
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) err_cnt_q <= '0;
        else if (accept && err_txn && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = '0;
`endif
endmodule

// File: tb/tb_obi_subordinate_mem.sv
// Scoreboard bench for obi_subordinate_mem: stimulus pushes expected responses, a monitor pops and compares.
module tb_obi_subordinate_mem;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0, we = 1'b0, rready = 1'b1;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  be = '0;
    logic        gnt, rvalid, err, busy;
    logic [31:0] rdata;
    logic [7:0]  err_cnt;

    logic        req3 = 1'b0;
    logic        gnt3, rvalid3, err3, busy3;
    logic [31:0] rdata3;
    logic [7:0]  err_cnt3;

    int pass_cnt = 0, chk_cnt = 0;
    logic [32:0] sb_q [$];

    always #5 clk = ~clk;

    obi_subordinate_mem #(.GNT_WAIT(0), .RSP_DEPTH(2)) dut (
        .clk_i(clk), .reset_ni(rst_n), .obi_req_i(req), .obi_gnt_o(gnt),
        .obi_addr_i(addr), .obi_we_i(we), .obi_be_i(be), .obi_wdata_i(wdata),
        .obi_rvalid_o(rvalid), .obi_rready_i(rready), .obi_rdata_o(rdata),
        .obi_err_o(err), .busy_o(busy), .err_cnt_o(err_cnt));

    obi_subordinate_mem #(.GNT_WAIT(3)) dut3 (
        .clk_i(clk), .reset_ni(rst_n), .obi_req_i(req3), .obi_gnt_o(gnt3),
        .obi_addr_i(32'h0), .obi_we_i(1'b0), .obi_be_i(4'hF), .obi_wdata_i(32'h0),
        .obi_rvalid_o(rvalid3), .obi_rready_i(1'b1), .obi_rdata_o(rdata3),
        .obi_err_o(err3), .busy_o(busy3), .err_cnt_o(err_cnt3));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every R-channel handshake must match the oldest expected response.
    always @(negedge clk) begin
        if (rst_n && rvalid && rready) begin
            if (sb_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL rsp_unexpected: got rdata 0x%0h err %0b with nothing expected", rdata, err);
            end else begin
                logic [32:0] e;
                e = sb_q.pop_front();
                chk("rsp", {31'h0, err, rdata}, {31'h0, e});
            end
        end
    end

    // Drive one A-channel request; on grant, queue the expected {err, rdata}.
    task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee,
                         output int waits);
        req = 1'b1; addr = a; we = w; be = b; wdata = wd; waits = 0;
        @(negedge clk);
        while (!gnt && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (gnt) sb_q.push_back({ee, er});
        else chk("issue_timeout", 64'(waits), 64'd0);
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic measure3(output int n);
        req3 = 1'b1; n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt3 && n < 20);
        @(posedge clk); #1;
        req3 = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb_q.size() != 0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drained", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        int w, n;
        logic [7:0] exp_cnt;
        #2;
        chk("rst_gnt", gnt, 0); chk("rst_rvalid", rvalid, 0); chk("rst_rdata", rdata, 0);
        chk("rst_err", err, 0); chk("rst_busy", busy, 0); chk("rst_errcnt", err_cnt, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic write then read back.
        issue(32'h8, 1, 4'hF, 32'hDEADBEEF, 32'h0, 0, w);
        chk("gnt_wait0_wr", w, 0);
        issue(32'h8, 0, 4'hF, 32'h0, 32'hDEADBEEF, 0, w);
        chk("gnt_wait0_rd", w, 0);
        chk("rd_latency", rvalid, 1);

        // Byte enables over zeroed memory; partial be read returns full word.
        issue(32'h4, 1, 4'h5, 32'hAABBCCDD, 32'h0, 0, w);
        issue(32'h4, 0, 4'h1, 32'h0, 32'h00BB00DD, 0, w);
        issue(32'hC, 1, 4'h0, 32'h12345678, 32'h0, 0, w);
        issue(32'hC, 0, 4'hF, 32'h0, 32'h0, 0, w);

        // Grant latency with GNT_WAIT = 3, including restart after dropping req.
        measure3(n);
        chk("gnt3_first", n, 4);
        req3 = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("gnt3_held", gnt3, 0);
        @(posedge clk); #1;
        req3 = 1'b0;
        @(posedge clk); #1;
        measure3(n);
        chk("gnt3_restart", n, 4);

        // Range and alignment errors leave memory untouched.
        issue(32'h40, 0, 4'hF, 32'h0, 32'h0, 1, w);
        issue(32'h42, 1, 4'hF, 32'hFFFFFFFF, 32'h0, 1, w);
        issue(32'h6, 1, 4'hF, 32'hFFFFFFFF, 32'h0, 1, w);
        issue(32'h4, 0, 4'hF, 32'h0, 32'h00BB00DD, 0, w);
        drain();
`ifdef OBI_SBR_ERR_CNT_EN
        exp_cnt = 8'd3;
`else
        exp_cnt = 8'd0;
`endif
        chk("err_cnt_3", err_cnt, exp_cnt);

        // Backpressure: two responses fill the buffer, third request waits.
        rready = 1'b0;
        issue(32'h0, 0, 4'hF, 32'h0, 32'h0, 0, w);
        issue(32'h4, 0, 4'hF, 32'h0, 32'h00BB00DD, 0, w);
        chk("bp_busy", busy, 1);
        req = 1'b1; addr = 32'h8; we = 1'b0; be = 4'hF;
        @(negedge clk);
        chk("bp_gnt_full", gnt, 0);
        @(posedge clk); #1;
        rready = 1'b1;
        @(negedge clk);
        chk("bp_gnt_pop_cycle", gnt, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_gnt_after_pop", gnt, 1);
        if (gnt) sb_q.push_back({1'b0, 32'hDEADBEEF});
        @(posedge clk); #1;
        req = 1'b0;
        drain();

        // Error counter saturation.
        for (int i = 0; i < 300; i++) issue(32'h40, 0, 4'hF, 32'h0, 32'h0, 1, w);
        drain();
`ifdef OBI_SBR_ERR_CNT_EN
        exp_cnt = 8'd255;
`else
        exp_cnt = 8'd0;
`endif
        chk("err_cnt_sat", err_cnt, exp_cnt);

        // Reset with two buffered responses and a pending request.
        rready = 1'b0;
        issue(32'h8, 0, 4'hF, 32'h0, 32'hDEADBEEF, 0, w);
        issue(32'h0, 0, 4'hF, 32'h0, 32'h0, 0, w);
        chk("pre_rst_busy", busy, 1);
        req = 1'b1; addr = 32'h4;
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", rvalid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_errcnt", err_cnt, 0);
        sb_q.delete();
        req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rready = 1'b1;
        @(posedge clk); #1;
        issue(32'h8, 0, 4'hF, 32'h0, 32'h0, 0, w);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/obi_subordinate_mem.md
Name: obi_subordinate_mem

Overview:
- Word-addressed memory subordinate on the OBI A/R channels.
- Consumes requests from the team's single-transaction OBI master (obi_master) and answers every accepted transaction with exactly one R-channel response.
- Used as the bench/SoC-side endpoint for the master. Provides programmable grant latency, a small response buffer for R-channel backpressure, and address-range error reporting.

Parameters:
- ADDR_WIDTH, 32, address width in bits (32 or 64).
- DATA_WIDTH, 32, data width in bits (32 or 64).
- DEPTH, 16, number of DATA_WIDTH words in storage.
- BASE_ADDR, 0, byte address of word 0.
- GNT_WAIT, 0, cycles obi_req_i must be held high before obi_gnt_o may assert (0 to 15).
- RSP_DEPTH, 2, response buffer entries (power of 2, at least 1).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_ni  in  1  asynchronous active-low reset.
- obi_req_i  in  1  A-channel request.
- obi_gnt_o  out  1  A-channel grant.
- obi_addr_i  in  ADDR_WIDTH  byte address.
- obi_we_i  in  1  1 = write, 0 = read.
- obi_be_i  in  DATA_WIDTH/8  byte enables.
- obi_wdata_i  in  DATA_WIDTH  write data.
- obi_rvalid_o  out  1  response valid.
- obi_rready_i  in  1  response ready.
- obi_rdata_o  out  DATA_WIDTH  read data; 0 for writes and errors.
- obi_err_o  out  1  error flag for the response.
- busy_o  out  1  high while the response buffer is non-empty.
- err_cnt_o  out  8  error count; see Optional Feature.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - obi_gnt_o = 0, obi_rvalid_o = 0, obi_rdata_o = 0, obi_err_o = 0, busy_o = 0, err_cnt_o = 0.
  - Wait counter = 0; buffer pointers and count = 0; all memory words = 0.
  - Any in-flight or buffered response is discarded.
- Grant (wait counter wcnt, 4 bits):
  - obi_gnt_o = obi_req_i && (wcnt == GNT_WAIT) && !rsp_full. This is combinational from obi_req_i.
  - wcnt increments while obi_req_i = 1 and there is no acceptance, saturating at GNT_WAIT.
  - wcnt clears to 0 on acceptance or when obi_req_i = 0.
  - With GNT_WAIT = 0, grant is in the same cycle as the request if the buffer is not full.
- Acceptance: a cycle with obi_req_i && obi_gnt_o.
  - Address and attributes are sampled only in the acceptance cycle.
  - Changes on the A channel before grant are ignored.
- Error: index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8). An accepted transaction is an error if either:
  - addr < BASE_ADDR or index >= DEPTH, or
  - the address is not word-aligned.
  - Error responses: no memory update, rdata = 0, err = 1.
- Write:
  - Memory byte lanes with obi_be_i[k] = 1 are updated on the acceptance edge.
  - be = 0 is legal: no update, normal response.
  - Response has rdata = 0, err = 0.
- Read:
  - The memory word at index is captured on the acceptance edge (read-after-write ordering preserved because requests are serialized).
  - Partial obi_be_i still returns the full word.
- Response buffer: FIFO of {rdata, err}.
  - Push on the acceptance edge. Pop when obi_rvalid_o && obi_rready_i.
  - obi_rvalid_o = !empty; head entry drives obi_rdata_o/obi_err_o.
  - Head must stay stable while obi_rvalid_o && !obi_rready_i.
  - Minimum latency: acceptance at edge T gives obi_rvalid_o high in cycle T+1.
  - Pointers wrap modulo RSP_DEPTH.
  - When full: grant is withheld even if a pop occurs in the same cycle; grant resumes the cycle after the pop.
  - Simultaneous push and pop when not full: count unchanged, both operations take effect.
- Ordering: responses are returned strictly in acceptance order.
- busy_o = !empty.

Optional Feature:
- Macro: OBI_SBR_ERR_CNT_EN.
- When defined: err_cnt_o is an 8-bit counter, incremented on the acceptance edge of each error transaction, saturating at 255, cleared only by reset.
- When undefined: counter logic is not compiled, err_cnt_o is tied to 0, and port widths are unchanged.

Test Plan:
- GNT_WAIT = 0, BASE_ADDR = 0: write 0xDEADBEEF to 0x8 with be = 0xF, then read 0x8 → gnt in request cycle; write response err = 0, rdata = 0; read rvalid one cycle after acceptance with rdata = 0xDEADBEEF.
- Byte enables: write 0xAABBCCDD to 0x4 with be = 0x5 over reset memory, then read 0x4 → rdata = 0x00BB00DD.
- GNT_WAIT = 3: hold req high → gnt asserts in the 4th request cycle. Drop req after 2 cycles and re-raise → count restarts, gnt again in the 4th cycle.
- Errors: read 0x40 (DEPTH = 16), write 0x42 → both err = 1, rdata = 0, memory unchanged; with OBI_SBR_ERR_CNT_EN, err_cnt_o = 2. Drive 300 errors → err_cnt_o = 255.
- Backpressure, RSP_DEPTH = 2: hold rready = 0 and issue 3 reads of 0x0/0x4/0x8 → first two granted, third waits with gnt = 0. Raise rready → data returned in order; third granted the cycle after the first pop.
- Reset mid-operation: assert reset_ni = 0 with 2 buffered responses → rvalid = 0, busy_o = 0, gnt = 0 immediately; after release, read 0x8 returns 0.
